store_dispatch: RTL and testbench
=================================

// Module: store_dispatch
// PURPOSE
//  Write-direction counterpart of the writeback source select. Accepts one store
//  request (data + 3-bit destination code) from the datapath and delivers it to
//  the data RAM, the output-port register or the HD controller. Runs the
//  per-destination handshake and stalls the core via req_ready while busy.
//  Destination codes: 0 = RAM, 2 = OUT, 4 = HD. Codes 1, 3, 5, 6, 7 are illegal.
// PARAMETERS
//  DATA_W      32   store data width
//  ADDR_W      32   RAM/HD address width
//  HD_TIMEOUT  255  max cycles hd_req waits for hd_ack (>=1)
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       store request valid
//  req_ready  out  1       request accepted when req_valid && req_ready
//  dest       in   3       destination code, full 3-bit decode
//  addr       in   ADDR_W  target address (RAM/HD; ignored for OUT)
//  data       in   DATA_W  store data
//  ram_we     out  1       RAM write strobe, one cycle
//  ram_addr   out  ADDR_W  RAM address, valid while ram_we
//  ram_data   out  DATA_W  RAM write data, valid while ram_we
//  out_we     out  1       output-port update pulse, one cycle
//  out_data   out  DATA_W  output-port register, holds last value written
//  hd_req     out  1       HD write request, level until ack/timeout
//  hd_addr    out  ADDR_W  HD address, stable while hd_req
//  hd_data    out  DATA_W  HD data, stable while hd_req
//  hd_ack     in   1       HD completion, sampled only in HD state
//  err        out  1       sticky error flag
//  err_code   out  2       0 none, 1 illegal dest, 2 HD timeout
// BEHAVIOUR
//  - Reset (async): state IDLE, all outputs 0 (req_ready 0 while reset high, 1 in
//    the first cycle after release); out_data = 0; timeout counter = 0.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - States: IDLE, RAM, OUT, HD, BAD.
//  - IDLE: req_ready = 1. On accept edge latch dest/addr/data, clear err/err_code,
//    go to RAM (0), OUT (2), HD (4) or BAD (other codes).
//  - RAM: ram_we = 1 for exactly one cycle with latched addr/data -> IDLE.
//    Accept at edge N -> ram_we high in cycle N+1 -> req_ready high in cycle N+2.
//  - OUT: out_we = 1 for one cycle; out_data loads latched data on the accept edge
//    and holds until the next OUT store or reset -> IDLE.
//  - HD: hd_req = 1, hd_addr/hd_data held stable; counter increments each cycle.
//    hd_ack = 1 -> drop hd_req, IDLE. Counter == HD_TIMEOUT without ack -> drop
//    hd_req, err = 1, err_code = 2, IDLE. Ack and timeout same cycle: ack wins, no error.
//  - BAD: one cycle, no write strobe of any kind; err = 1, err_code = 1 -> IDLE.
//  - req_ready = 0 in every state except IDLE; back-to-back stores cost >= 2 cycles.
//  - hd_ack outside HD state ignored. Request inputs outside IDLE ignored.
//  - err/err_code hold until next accepted request or reset.
//  - Reset mid-HD: hd_req drops immediately (async); transaction abandoned, no error.
//  - At most one of ram_we, out_we, hd_req is high in any cycle.
// TESTING
//  1. dest=0, addr=0x10, data=0xDEADBEEF -> ram_we 1 cycle at N+1 with same addr/data; ready at N+2.
//  2. dest=2, data=0x0000002A -> out_we pulse; out_data=0x2A held through a following RAM store.
//  3. dest=4, hd_ack after 5 cycles -> hd_req high 5 cycles, addr/data stable, err=0.
//  4. dest=4, no ack, HD_TIMEOUT=8 -> hd_req drops after 8 cycles, err=1, err_code=2;
//     next store of dest=0 clears err.
//  5. dest=1, 3, 5, 7 -> no strobes, err=1, err_code=1; dest=6 likewise.
//  6. reset asserted during HD wait -> hd_req 0 same cycle, out_data=0, ready after release.

Source files
------------

// File: rtl/store_dispatch.sv
// Store dispatcher: routes one accepted store to the data RAM, the output-port
// register or the HD controller, running each destination's handshake.
module store_dispatch #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int HD_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        dest,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              out_we,
  output logic [DATA_W-1:0] out_data,
  output logic              hd_req,
  output logic [ADDR_W-1:0] hd_addr,
  output logic [DATA_W-1:0] hd_data,
  input  logic              hd_ack,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int CW = $clog2(HD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RAM, OUT, HD, BAD} state_t;

  state_t          state;
  logic [CW-1:0]   hdCnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      out_we    <= 1'b0;
      out_data  <= '0;
      hd_req    <= 1'b0;
      hd_addr   <= '0;
      hd_data   <= '0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      hdCnt     <= '0;
    end else begin
      ram_we <= 1'b0;
      out_we <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            case (dest)
              3'd0: begin
                state    <= RAM;
                ram_we   <= 1'b1;
                ram_addr <= addr;
                ram_data <= data;
              end
              3'd2: begin
                state    <= OUT;
                out_we   <= 1'b1;
                out_data <= data;
              end
              3'd4: begin
                state   <= HD;
                hd_req  <= 1'b1;
                hd_addr <= addr;
                hd_data <= data;
                // Counter holds the number of cycles hd_req has been high.
                hdCnt   <= CW'(1);
              end
              default: state <= BAD;
            endcase
          end
        end
        RAM, OUT: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        HD: begin
          if (hd_ack) begin
            hd_req    <= 1'b0;
            hdCnt     <= '0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else if (hdCnt == CW'(HD_TIMEOUT)) begin
            hd_req    <= 1'b0;
            hdCnt     <= '0;
            err       <= 1'b1;
            err_code  <= 2'd2;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            hdCnt <= hdCnt + 1'b1;
          end
        end
        BAD: begin
          err       <= 1'b1;
          err_code  <= 2'd1;
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_dispatch.sv
// Bench for store_dispatch: directed cases plus random stores checked against
// a per-transaction reference model of the expected handshake.
module tb_store_dispatch;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    dest;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          out_we;
  logic [DW-1:0] out_data;
  logic          hd_req;
  logic [AW-1:0] hd_addr;
  logic [DW-1:0] hd_data;
  logic          hd_ack;
  logic          err;
  logic [1:0]    err_code;

  always #5 clock = ~clock;

  store_dispatch #(.DATA_W(DW), .ADDR_W(AW), .HD_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .dest(dest), .addr(addr), .data(data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .out_we(out_we), .out_data(out_data),
    .hd_req(hd_req), .hd_addr(hd_addr), .hd_data(hd_data), .hd_ack(hd_ack),
    .err(err), .err_code(err_code)
  );

  int passCnt = 0;
  int totalCnt = 0;
  logic [DW-1:0] expOut = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Noise on request inputs while busy; they must be ignored.
  task automatic noise(input bit touchAck);
    req_valid = 1'($urandom_range(0, 1));
    dest      = 3'($urandom_range(0, 7));
    addr      = $urandom;
    data      = $urandom;
    if (touchAck) hd_ack = 1'($urandom_range(0, 1));
  endtask

  // ackAt: hd_req cycle (1-based) during which hd_ack is raised; 0 = never.
  task automatic store(input logic [2:0] d, input logic [AW-1:0] a,
                       input logic [DW-1:0] dt, input int ackAt);
    int  n;
    int  hiCycles;
    bit  timeout;
    logic [1:0] expCode;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", {63'd0, req_ready}, 64'd1);
    chk("idle_quiet", {61'd0, ram_we, out_we, hd_req}, 64'd0);
    req_valid = 1'b1; dest = d; addr = a; data = dt;
    hd_ack = (d == 3'd4) ? 1'b0 : 1'($urandom_range(0, 1));
    @(negedge clock);
    noise(d != 3'd4);
    chk("busy_ready", {63'd0, req_ready}, 64'd0);
    chk("err_cleared", {61'd0, err, err_code}, 64'd0);
    timeout = !(ackAt >= 1 && ackAt <= TO);
    case (d)
      3'd0: begin
        expCode = 2'd0;
        chk("ram_we", {63'd0, ram_we}, 64'd1);
        chk("ram_addr", 64'(ram_addr), 64'(a));
        chk("ram_data", 64'(ram_data), 64'(dt));
        chk("ram_excl", {62'd0, out_we, hd_req}, 64'd0);
      end
      3'd2: begin
        expCode = 2'd0;
        expOut  = dt;
        chk("out_we", {63'd0, out_we}, 64'd1);
        chk("out_data_new", 64'(out_data), 64'(dt));
        chk("out_excl", {62'd0, ram_we, hd_req}, 64'd0);
      end
      3'd4: begin
        expCode  = timeout ? 2'd2 : 2'd0;
        hiCycles = timeout ? TO : ackAt;
        for (int k = 1; k <= hiCycles; k++) begin
          if (k > 1) begin
            @(negedge clock);
            noise(1'b0);
          end
          chk("hd_req", {63'd0, hd_req}, 64'd1);
          chk("hd_addr", 64'(hd_addr), 64'(a));
          chk("hd_data", 64'(hd_data), 64'(dt));
          chk("hd_busy", {62'd0, req_ready, ram_we}, 64'd0);
          hd_ack = (k == ackAt);
        end
      end
      default: begin
        expCode = 2'd1;
        chk("bad_quiet", {61'd0, ram_we, out_we, hd_req}, 64'd0);
      end
    endcase
    @(negedge clock);
    req_valid = 1'b0;
    hd_ack    = 1'b0;
    chk("done_quiet", {61'd0, ram_we, out_we, hd_req}, 64'd0);
    chk("done_ready", {63'd0, req_ready}, 64'd1);
    chk("done_err", {61'd0, err, err_code}, {61'd0, expCode != 2'd0, expCode});
    chk("out_hold", 64'(out_data), 64'(expOut));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; hd_ack = 1'b0;
    dest = '0; addr = '0; data = '0;
    #12;
    chk("rst_outputs", {58'd0, req_ready, ram_we, out_we, hd_req, err, err_code}, 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_ready_low", {63'd0, req_ready}, 64'd0);
    @(negedge clock);
    chk("rst_ready_rel", {63'd0, req_ready}, 64'd1);

    store(3'd0, 32'h10, 32'hDEADBEEF, 0);
    store(3'd2, 32'h0, 32'h0000002A, 0);
    store(3'd0, 32'h20, 32'h00001234, 0);
    store(3'd4, 32'h30, 32'h0000CAFE, 5);
    store(3'd4, 32'h40, 32'h0000BEEF, 0);
    store(3'd0, 32'h50, 32'h11111111, 0);
    store(3'd4, 32'h60, 32'h22222222, TO);
    store(3'd4, 32'h70, 32'h33333333, TO + 1);
    store(3'd4, 32'h80, 32'h44444444, 1);
    store(3'd1, 32'h90, 32'h55555555, 0);
    store(3'd3, 32'h90, 32'h55555555, 0);
    store(3'd5, 32'h90, 32'h55555555, 0);
    store(3'd7, 32'h90, 32'h55555555, 0);
    store(3'd6, 32'h90, 32'h55555555, 0);
    store(3'd2, 32'h0, 32'hA5A5A5A5, 0);

    // Reset in the middle of an HD wait.
    req_valid = 1'b1; dest = 3'd4; addr = 32'hAA; data = 32'hBB; hd_ack = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("hd_before_rst", {63'd0, hd_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_hd_drop", {58'd0, req_ready, ram_we, out_we, hd_req, err, err_code}, 64'd0);
    chk("rst_out_clr", 64'(out_data), 64'd0);
    expOut = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    store(3'd0, 32'hCC, 32'hDD, 0);

    for (int i = 0; i < 40; i++)
      store(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, TO + 2)));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
